// File: rtl/uart_tx_queue_pkg.sv
// Shared UART definitions: handshake FSM encoding and 27 MHz baud constants.
package uart_tx_queue_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_END  = 2'd3
  } state_e;

  // Bit period and half bit period in 27 MHz clocks at 9600 baud.
  localparam int BAUD_DIV_27M  = 2812;
  localparam int BAUD_HALF_27M = 1406;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU push side and transmitter load side of the UART TX queue.
interface uart_tx_queue_if
  import uart_tx_queue_pkg::*;
#(
  parameter int AW = 3
) ();

  // wr_en is a push strobe: a byte is taken on every clock where wr_en=1 and
  // full=0, otherwise it is dropped and overflow is set. tx_en is a one-cycle
  // load strobe; the transmitter acknowledges by dropping tx_status and then
  // pulsing tx_end when its stop bit completes.
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          ovf_clr;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_status;
  logic          tx_end;
  state_e        dbg_state;

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_status, tx_end,
    output full, empty, count, overflow, tx_busy, tx_data, tx_en, dbg_state
  );

  modport master (
    output wr_en, wr_data, ovf_clr, tx_status, tx_end,
    input  full, empty, count, overflow, tx_busy, tx_data, tx_en, dbg_state
  );

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Circular byte buffer with occupancy count; pushes while full are refused
// even when a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// UART TX queue: byte FIFO feeding a transmitter through a
// launch / wait-busy / wait-end handshake, with a sticky overflow flag.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic              clk,
  input logic              rst,
  uart_tx_queue_if.slave   bus
);

  state_e      state_q, state_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        overflow_q, overflow_d;
  logic        pop;
  logic [7:0]  fifo_dout;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_en),
    .pop   (pop),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.tx_status) begin
          tx_data_d = fifo_dout;
          tx_en_d   = 1'b1;
          pop       = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_status) state_d = WAIT_END;
      // tx_end is only meaningful here; elsewhere it is ignored.
      WAIT_END:  if (bus.tx_end) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A push refused for fullness beats a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.wr_en && fifo_full) overflow_d = 1'b1;
    else if (bus.ovf_clr)       overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_q;
  assign bus.tx_busy   = (state_q != IDLE) || !fifo_empty;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with an optional transmitter model that
// drops status after a load and pulses end 20 cycles later.
module tb_uart_tx_queue;
  import uart_tx_queue_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   launch_cnt;
  int   frame_cnt;
  logic model_on;

  logic [7:0] exp_q[$];
  logic [7:0] launch_data[$];
  int         launch_cyc[$];
  int         end_cyc[$];

  uart_tx_queue_if #(.AW(3)) bus ();

  uart_tx_queue #(
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance one edge, sample 1 time unit later, then run the transmitter model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.tx_end = 1'b0;
    if (bus.tx_en === 1'b1) begin
      launch_cnt++;
      launch_data.push_back(bus.tx_data);
      launch_cyc.push_back(cyc);
    end
    if (model_on) begin
      if (bus.tx_en === 1'b1) begin
        bus.tx_status = 1'b0;
        frame_cnt     = 20;
      end else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) begin
          bus.tx_end    = 1'b1;
          bus.tx_status = 1'b1;
          end_cyc.push_back(cyc);
        end
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic clear_records();
    launch_data.delete();
    launch_cyc.delete();
    end_cyc.delete();
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.full, bus.empty, bus.count, bus.overflow, bus.tx_en, bus.tx_busy} !== 9'b0_1_0000_0_0_0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 010000000",
               {bus.full, bus.empty, bus.count, bus.overflow, bus.tx_en, bus.tx_busy});
    end
    checks++;
    if (bus.tx_data !== 8'h00 || bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_data_state got %h/%0d exp 00/0", bus.tx_data, bus.dbg_state);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus.full, bus.empty, bus.count, bus.tx_busy} !== 7'b0_1_0000_0) begin
      errors++;
      $display("FAIL post_reset got %b exp 0100000", {bus.full, bus.empty, bus.count, bus.tx_busy});
    end
  endtask

  task automatic test_single_launch();
    bus.tx_status = 1'b1;
    push(8'h55);
    checks++;
    if (bus.count !== 4'd1 || bus.tx_en !== 1'b0) begin
      errors++;
      $display("FAIL single_push count/tx_en got %0d/%b exp 1/0", bus.count, bus.tx_en);
    end
    step();
    checks++;
    if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h55 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL single_launch en/data/count got %b/%h/%0d exp 1/55/0", bus.tx_en, bus.tx_data, bus.count);
    end
    step();
    checks++;
    if (bus.tx_en !== 1'b0 || bus.tx_data !== 8'h55 || bus.dbg_state !== WAIT_BUSY) begin
      errors++;
      $display("FAIL single_load en/data/state got %b/%h/%0d exp 0/55/2", bus.tx_en, bus.tx_data, bus.dbg_state);
    end
    bus.tx_status = 1'b0;
    step();
    bus.tx_status = 1'b1;
    bus.tx_end    = 1'b1;
    step();
    checks++;
    if (bus.dbg_state !== IDLE || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done state/busy got %0d/%b exp 0/0", bus.dbg_state, bus.tx_busy);
    end
  endtask

  task automatic test_frame_spacing();
    int n;
    model_on      = 1'b0;
    bus.tx_status = 1'b0;
    for (int i = 1; i <= 3; i++) push(8'(i));
    clear_records();
    for (int i = 1; i <= 3; i++) exp_q.push_back(8'(i));
    model_on      = 1'b1;
    bus.tx_status = 1'b1;
    n = 0;
    while ((launch_data.size() < 3 || end_cyc.size() < 3) && n < 300) begin
      step();
      n++;
    end
    step();
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL spacing_timeout got %0d launches exp 3", launch_data.size());
    end
    checks++;
    if (launch_data.size() != 3) begin
      errors++;
      $display("FAIL spacing_launches got %0d exp 3", launch_data.size());
    end
    for (int i = 0; i < launch_data.size() && exp_q.size() > 0; i++) begin
      checks++;
      if (launch_data[i] !== exp_q[0]) begin
        errors++;
        $display("FAIL spacing_order[%0d] got %h exp %h", i, launch_data[i], exp_q[0]);
      end
      void'(exp_q.pop_front());
      if (i > 0 && end_cyc.size() >= i) begin
        checks++;
        if (launch_cyc[i] - end_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL spacing_gap[%0d] got %0d exp 2", i, launch_cyc[i] - end_cyc[i-1]);
        end
      end
    end
    model_on = 1'b0;
  endtask

  task automatic test_fill_overflow();
    bus.tx_status = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    checks++;
    if ({bus.full, bus.empty, bus.count, bus.tx_busy} !== 7'b1_0_1000_1) begin
      errors++;
      $display("FAIL fill_flags got %b exp 1010001", {bus.full, bus.empty, bus.count, bus.tx_busy});
    end
    push(8'hAA);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL fill_overflow ovf/count got %b/%0d exp 1/8", bus.overflow, bus.count);
    end
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_ovf_clr got %b exp 0", bus.overflow);
    end
  endtask

  task automatic test_ovf_clr();
    bus.ovf_clr = 1'b1;
    push(8'hBB);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_set_wins ovf/count got %b/%0d exp 1/8", bus.overflow, bus.count);
    end
    step();
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_alone got %b exp 0", bus.overflow);
    end
  endtask

  task automatic test_full_pop();
    int n;
    clear_records();
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    model_on      = 1'b1;
    bus.tx_status = 1'b1;
    push(8'hCC);
    checks++;
    if (bus.count !== 4'd7 || bus.overflow !== 1'b1 || bus.tx_en !== 1'b1 || bus.tx_data !== 8'h01) begin
      errors++;
      $display("FAIL full_pop count/ovf/en/data got %0d/%b/%b/%h exp 7/1/1/01",
               bus.count, bus.overflow, bus.tx_en, bus.tx_data);
    end
    n = 0;
    while (!(bus.empty === 1'b1 && bus.dbg_state === IDLE && end_cyc.size() >= 8) && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (n >= 600 || launch_data.size() != 8) begin
      errors++;
      $display("FAIL drain_launches got %0d exp 8", launch_data.size());
    end
    for (int i = 0; i < launch_data.size() && exp_q.size() > 0; i++) begin
      checks++;
      if (launch_data[i] !== exp_q[0]) begin
        errors++;
        $display("FAIL drain_order[%0d] got %h exp %h", i, launch_data[i], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    model_on    = 1'b0;
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int base;
    bus.tx_status = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
    bus.tx_status = 1'b1;
    step();
    bus.tx_status = 1'b0;
    step();
    step();
    checks++;
    if (bus.dbg_state !== WAIT_END || bus.count !== 4'd4) begin
      errors++;
      $display("FAIL midframe_setup state/count got %0d/%0d exp 3/4", bus.dbg_state, bus.count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.tx_en !== 1'b0 || bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL midframe_async count/empty/en/state got %0d/%b/%b/%0d exp 0/1/0/0",
               bus.count, bus.empty, bus.tx_en, bus.dbg_state);
    end
    step();
    step();
    rst           = 1'b0;
    bus.tx_status = 1'b1;
    base          = launch_cnt;
    repeat (10) step();
    checks++;
    if (launch_cnt != base || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_launch launches/busy got %0d/%b exp %0d/0", launch_cnt, bus.tx_busy, base);
    end
    push(8'h77);
    step();
    checks++;
    if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h77) begin
      errors++;
      $display("FAIL midframe_relaunch en/data got %b/%h exp 1/77", bus.tx_en, bus.tx_data);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    launch_cnt    = 0;
    frame_cnt     = 0;
    model_on      = 1'b0;
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.ovf_clr   = 1'b0;
    bus.tx_status = 1'b1;
    bus.tx_end    = 1'b0;

    test_reset();
    test_single_launch();
    test_frame_spacing();
    test_fill_overflow();
    test_ovf_clr();
    test_full_pop();
    test_reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
